iob_responder: RTL

Synchronous 68000-style I/O bus target for the CLK_IOB domain. It is the responding end of the PDS cycles that the I/O bus master issues, and serves as the bench/bring-up stand-in for Mac glue logic. It decodes each nAS cycle into one of three regions: a DTACK scratch-register region, a VPA/E-clock 6800-peripheral region, or unmapped space, which is terminated with nBERR after a timeout. It also generates the free-running E clock that the master synchronizes VPA cycles to.

---
 rtl/iob_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/iob_responder.sv
// 68000-style I/O bus target: DTACK scratch registers, VPA/E-clock peripheral window and
// nBERR termination of unmapped cycles, plus the free-running E clock generator.
module iob_responder #(
   parameter logic [3:0]  MEM_REGION = 4'h0,
   parameter logic [3:0]  VPA_REGION = 4'hE,
   parameter int unsigned DTACK_WS   = 2,
   parameter int unsigned TIMEOUT    = 63
) (
   input  logic        CLK_IOB,
   input  logic        RES,
   input  logic [23:1] A_IOB,
   input  logic        nAS_IOB,
   input  logic        nUDS_IOB,
   input  logic        nLDS_IOB,
   input  logic        nWE_IOB,
   input  logic        nVMA_IOB,
   input  logic [15:0] D_IN,
   output logic [15:0] D_OUT,
   output logic        D_OE,
   output logic        nDTACK_IOB,
   output logic        nVPA_IOB,
   output logic        nBERR_IOB,
   output logic        E_IOB
);

   localparam logic [7:0] WsCnt      = 8'(DTACK_WS);
   localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

   typedef enum logic [2:0] {StIdle, StMem, StVpa, StBerr, StHold} state_e;

   state_e      state_q, state_d;
   logic [3:0]  idx_q, idx_d;
   logic        wr_q, wr_d;
   logic [7:0]  cnt_q, cnt_d, cnt_inc;
   logic        armed_q, armed_d;
   logic        rel_q, rel_d;
   logic [3:0]  ecnt_q, ecnt_d;
   logic        e_q, e_d;
   logic        dtack_n_q, dtack_n_d;
   logic        vpa_n_q, vpa_n_d;
   logic        berr_n_q, berr_n_d;
   logic [15:0] d_out_q, d_out_d;
   logic        d_oe_q, d_oe_d;
   logic [15:0] regs [16];
   logic        wen;
   logic        strobe;
   logic        unused_addr;

   assign unused_addr = ^A_IOB[19:5];
   assign strobe      = !nUDS_IOB || !nLDS_IOB;
   assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      wr_d      = wr_q;
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      rel_d     = rel_q;
      dtack_n_d = dtack_n_q;
      vpa_n_d   = vpa_n_q;
      berr_n_d  = berr_n_q;
      d_out_d   = d_out_q;
      d_oe_d    = d_oe_q;
      wen       = 1'b0;
      ecnt_d    = (ecnt_q == 4'd9) ? 4'd0 : ecnt_q + 4'd1;
      e_d       = (ecnt_d >= 4'd6);

      // A cycle may only start once nAS has been seen high since the last start or reset.
      if (nAS_IOB) begin
         armed_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (!nAS_IOB && armed_q) begin
               idx_d   = A_IOB[4:1];
               wr_d    = !nWE_IOB;
               cnt_d   = 8'd0;
               armed_d = 1'b0;
               if (A_IOB[23:20] == MEM_REGION) begin
                  state_d = StMem;
               end else if (A_IOB[23:20] == VPA_REGION) begin
                  state_d = StVpa;
               end else begin
                  state_d = StBerr;
               end
            end
         end
         StMem: begin
            if (nAS_IOB) begin
               state_d = StIdle;
               d_oe_d  = 1'b0;
            end else begin
               cnt_d = cnt_inc;
               if (!wr_q) begin
                  d_out_d = regs[idx_q];
                  d_oe_d  = 1'b1;
               end
               if (cnt_q >= WsCnt && strobe) begin
                  dtack_n_d = 1'b0;
                  wen       = wr_q;
                  state_d   = StHold;
               end else if (cnt_q >= TimeoutCnt) begin
                  berr_n_d = 1'b0;
                  d_oe_d   = 1'b0;
                  state_d  = StHold;
               end
            end
         end
         StVpa: begin
            if (nAS_IOB) begin
               state_d = StIdle;
               vpa_n_d = 1'b1;
               d_oe_d  = 1'b0;
            end else begin
               cnt_d   = cnt_inc;
               vpa_n_d = 1'b0;
               if (!wr_q) begin
                  d_out_d = regs[idx_q];
                  d_oe_d  = 1'b1;
               end
               // The transfer edge is the 9->0 wrap of ECNT, i.e. the falling edge of E.
               if (ecnt_q == 4'd9 && !nVMA_IOB) begin
                  wen     = wr_q;
                  state_d = StHold;
               end else if (cnt_q >= TimeoutCnt) begin
                  vpa_n_d  = 1'b1;
                  berr_n_d = 1'b0;
                  d_oe_d   = 1'b0;
                  state_d  = StHold;
               end
            end
         end
         StBerr: begin
            cnt_d = cnt_inc;
            if (cnt_q >= TimeoutCnt) begin
               berr_n_d = 1'b0;
               state_d  = StHold;
            end
         end
         StHold: begin
            if (rel_q) begin
               dtack_n_d = 1'b1;
               vpa_n_d   = 1'b1;
               berr_n_d  = 1'b1;
               d_oe_d    = 1'b0;
               rel_d     = 1'b0;
               state_d   = StIdle;
            end else if (nAS_IOB) begin
               rel_d = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK_IOB) begin
      if (RES) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         armed_q   <= 1'b0;
         rel_q     <= 1'b0;
         ecnt_q    <= '0;
         e_q       <= 1'b0;
         dtack_n_q <= 1'b1;
         vpa_n_q   <= 1'b1;
         berr_n_q  <= 1'b1;
         d_out_q   <= '0;
         d_oe_q    <= 1'b0;
         for (int i = 0; i < 16; i++) begin
            regs[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         wr_q      <= wr_d;
         cnt_q     <= cnt_d;
         armed_q   <= armed_d;
         rel_q     <= rel_d;
         ecnt_q    <= ecnt_d;
         e_q       <= e_d;
         dtack_n_q <= dtack_n_d;
         vpa_n_q   <= vpa_n_d;
         berr_n_q  <= berr_n_d;
         d_out_q   <= d_out_d;
         d_oe_q    <= d_oe_d;
         if (wen) begin
            if (!nUDS_IOB) begin
               regs[idx_q][15:8] <= D_IN[15:8];
            end
            if (!nLDS_IOB) begin
               regs[idx_q][7:0] <= D_IN[7:0];
            end
         end
      end
   end

   assign D_OUT      = d_out_q;
   assign D_OE       = d_oe_q;
   assign nDTACK_IOB = dtack_n_q;
   assign nVPA_IOB   = vpa_n_q;
   assign nBERR_IOB  = berr_n_q;
   assign E_IOB      = e_q;

endmodule
